dff_mem_ctrl: RTL and testbench

//  Parametrised flip-flop RAM: next generation of the team's 16x8 DFF memory.
//  - Generic width and depth; per-bit write mask.
//  - Registered reads with a rd_valid strobe.
//  - Explicit conflict and error strobes.
//  - Hardware clear-on-reset sequencer, with busy held high while it runs.

---
 rtl/dff_mem_ctrl_if.sv | 28 ++
 rtl/dff_mem_ctrl.sv | 128 ++++++++++++
 tb/tb_dff_mem_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dff_mem_ctrl_if.sv
// Request/response bundle for dff_mem_ctrl: the master drives requests,
// the slave (the memory) returns read data and status strobes.
interface dff_mem_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();
  logic              ena;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] wmask;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rdata;
  logic              rd_valid;
  logic              conflict;
  logic              err;
  logic              busy;

  modport master (
    output ena, addr, wdata, wmask, wr_en, rd_en,
    input  rdata, rd_valid, conflict, err, busy
  );

  modport slave (
    input  ena, addr, wdata, wmask, wr_en, rd_en,
    output rdata, rd_valid, conflict, err, busy
  );
endinterface

// File: rtl/dff_mem_ctrl.sv
// Parametrised flip-flop RAM with per-bit write mask, registered reads and a
// post-reset clear sweep that holds busy high while it runs.
//
//   state    | meaning
//   ST_CLEAR | sweeping CLEAR_VAL into every word; requests rejected with err
//   ST_IDLE  | normal operation, serving single read/write requests
module dff_mem_ctrl #(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 4,
  parameter int                DEPTH          = 16,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
  input logic           clk,
  input logic           rst_n,
  dff_mem_ctrl_if.slave bus
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rd_valid;
  logic              r_conflict;
  logic              r_err;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_clr_ptr_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              w_rd_valid_nxt;
  logic              w_conflict_nxt;
  logic              w_err_nxt;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_in_range;
  logic              w_both;
  logic              w_single;

  assign w_in_range = ({1'b0, bus.addr} < DEPTH_X);
  assign w_rd_word  = w_in_range ? r_mem[bus.addr] : '0;
  assign w_both     = bus.ena & bus.wr_en & bus.rd_en;
  assign w_single   = bus.ena & (bus.wr_en ^ bus.rd_en);

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_ptr_nxt  = r_clr_ptr;
    w_rdata_nxt    = r_rdata;
    w_rd_valid_nxt = 1'b0;
    w_conflict_nxt = 1'b0;
    w_err_nxt      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr     = bus.addr;
    w_mem_wdata    = (w_rd_word & ~bus.wmask) | (bus.wdata & bus.wmask);
    case (r_state)
      ST_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clr_ptr;
        w_mem_wdata = CLEAR_VAL;
        if (r_clr_ptr == LAST_PTR) begin
          w_state_nxt   = ST_IDLE;
          w_clr_ptr_nxt = '0;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        end
        // Conflict outranks err even while sweeping, keeping them exclusive.
        if (w_both) begin
          w_conflict_nxt = 1'b1;
        end else if (w_single) begin
          w_err_nxt = 1'b1;
        end
      end
      default: begin
        if (w_both) begin
          w_conflict_nxt = 1'b1;
        end else if (w_single) begin
          if (!w_in_range) begin
            w_err_nxt = 1'b1;
          end else if (bus.wr_en) begin
            w_mem_we = 1'b1;
          end else begin
            w_rdata_nxt    = w_rd_word;
            w_rd_valid_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      r_clr_ptr  <= '0;
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
      r_conflict <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_ptr  <= w_clr_ptr_nxt;
      r_rdata    <= w_rdata_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_conflict <= w_conflict_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Storage has no reset; the sweep (or the user) initialises it.
  always_ff @(posedge clk) begin
    if (rst_n && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign bus.rdata    = r_rdata;
  assign bus.rd_valid = r_rd_valid;
  assign bus.conflict = r_conflict;
  assign bus.err      = r_err;
  assign bus.busy     = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_dff_mem_ctrl.sv
// Directed bench for dff_mem_ctrl: a 16-word and a 12-word instance share
// clock and reset; each task drives one scenario and checks inline.
module tb_dff_mem_ctrl;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  dff_mem_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus16 ();
  dff_mem_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus12 ();

  dff_mem_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .CLEAR_ON_RESET(1), .CLEAR_VAL(8'h00))
    u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  dff_mem_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .CLEAR_ON_RESET(1), .CLEAR_VAL(8'h00))
    u_dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle16();
    bus16.ena = 1'b1; bus16.wr_en = 1'b0; bus16.rd_en = 1'b0;
    bus16.addr = '0; bus16.wdata = '0; bus16.wmask = '0;
  endtask

  task automatic idle12();
    bus12.ena = 1'b1; bus12.wr_en = 1'b0; bus12.rd_en = 1'b0;
    bus12.addr = '0; bus12.wdata = '0; bus12.wmask = '0;
  endtask

  task automatic count_busy(output int d16, output int d12);
    d16 = 0; d12 = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!bus16.busy && d16 == 0) d16 = i;
      if (!bus12.busy && d12 == 0) d12 = i;
      if (d16 != 0 && d12 != 0) break;
    end
  endtask

  task automatic test_reset();
    int d16, d12;
    rst_n = 1'b0; idle16(); idle12();
    tick();
    tests_run++; if (bus16.rdata !== 8'h00) begin tests_failed++; $display("FAIL reset_rdata: got %h want 00", bus16.rdata); end
    tests_run++; if ({bus16.rd_valid, bus16.conflict, bus16.err} !== 3'b000) begin tests_failed++; $display("FAIL reset_strobes: got %b want 000", {bus16.rd_valid, bus16.conflict, bus16.err}); end
    tests_run++; if (bus16.busy !== 1'b1) begin tests_failed++; $display("FAIL reset_busy: got %b want 1", bus16.busy); end
    rst_n = 1'b1;
    count_busy(d16, d12);
    tests_run++; if (d16 != 16) begin tests_failed++; $display("FAIL sweep_len16: got %0d want 16", d16); end
    tests_run++; if (d12 != 12) begin tests_failed++; $display("FAIL sweep_len12: got %0d want 12", d12); end
    for (int a = 0; a < 16; a++) begin
      bus16.rd_en = 1'b1; bus16.addr = 4'(a);
      tick();
      tests_run++; if (bus16.rd_valid !== 1'b1 || bus16.rdata !== 8'h00) begin tests_failed++; $display("FAIL clear_read[%0d]: valid=%b data=%h want 1/00", a, bus16.rd_valid, bus16.rdata); end
    end
    idle16();
    tick();
    tests_run++; if (bus16.rd_valid !== 1'b0) begin tests_failed++; $display("FAIL clear_read_end: rd_valid=%b want 0", bus16.rd_valid); end
  endtask

  task automatic test_write_read();
    bus16.wr_en = 1'b1; bus16.addr = 4'd3; bus16.wdata = 8'hA5; bus16.wmask = 8'hFF;
    tick();
    tests_run++; if ({bus16.rd_valid, bus16.conflict, bus16.err} !== 3'b000) begin tests_failed++; $display("FAIL write_strobes: got %b want 000", {bus16.rd_valid, bus16.conflict, bus16.err}); end
    idle16(); bus16.rd_en = 1'b1; bus16.addr = 4'd3;
    tick();
    tests_run++; if (bus16.rd_valid !== 1'b1 || bus16.rdata !== 8'hA5) begin tests_failed++; $display("FAIL read_a5: valid=%b data=%h want 1/a5", bus16.rd_valid, bus16.rdata); end
    idle16();
    tick();
    tests_run++; if (bus16.rd_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_valid_pulse: got %b want 0", bus16.rd_valid); end
    bus16.wr_en = 1'b1; bus16.addr = 4'd3; bus16.wdata = 8'h00; bus16.wmask = 8'h0F;
    tick();
    idle16(); bus16.rd_en = 1'b1; bus16.addr = 4'd3;
    tick();
    tests_run++; if (bus16.rdata !== 8'hA0) begin tests_failed++; $display("FAIL masked_write: got %h want a0", bus16.rdata); end
    idle16();
    tick();
  endtask

  task automatic test_conflict();
    bus16.wr_en = 1'b1; bus16.rd_en = 1'b1; bus16.addr = 4'd3; bus16.wdata = 8'hFF; bus16.wmask = 8'hFF;
    tick();
    tests_run++; if ({bus16.conflict, bus16.rd_valid, bus16.err} !== 3'b100) begin tests_failed++; $display("FAIL conflict_strobes: got %b want 100", {bus16.conflict, bus16.rd_valid, bus16.err}); end
    tests_run++; if (bus16.rdata !== 8'hA0) begin tests_failed++; $display("FAIL conflict_rdata_held: got %h want a0", bus16.rdata); end
    idle16();
    tick();
    tests_run++; if (bus16.conflict !== 1'b0) begin tests_failed++; $display("FAIL conflict_pulse: got %b want 0", bus16.conflict); end
    bus16.rd_en = 1'b1; bus16.addr = 4'd3;
    tick();
    tests_run++; if (bus16.rdata !== 8'hA0) begin tests_failed++; $display("FAIL conflict_no_write: got %h want a0", bus16.rdata); end
    idle16();
    tick();
  endtask

  task automatic test_out_of_range();
    bus12.wr_en = 1'b1; bus12.addr = 4'd5; bus12.wdata = 8'h5A; bus12.wmask = 8'hFF;
    tick();
    bus12.addr = 4'd11; bus12.wdata = 8'h77;
    tick();
    tests_run++; if (bus12.err !== 1'b0) begin tests_failed++; $display("FAIL oor_last_word_err: got %b want 0", bus12.err); end
    idle12(); bus12.rd_en = 1'b1; bus12.addr = 4'd11;
    tick();
    tests_run++; if (bus12.rdata !== 8'h77) begin tests_failed++; $display("FAIL oor_last_word_read: got %h want 77", bus12.rdata); end
    bus12.addr = 4'd5;
    tick();
    tests_run++; if (bus12.rdata !== 8'h5A) begin tests_failed++; $display("FAIL oor_read5: got %h want 5a", bus12.rdata); end
    idle12(); bus12.wr_en = 1'b1; bus12.addr = 4'd13; bus12.wdata = 8'hFF; bus12.wmask = 8'hFF;
    tick();
    tests_run++; if ({bus12.err, bus12.conflict, bus12.rd_valid} !== 3'b100) begin tests_failed++; $display("FAIL oor_write_err: got %b want 100", {bus12.err, bus12.conflict, bus12.rd_valid}); end
    idle12(); bus12.rd_en = 1'b1; bus12.addr = 4'd13;
    tick();
    tests_run++; if ({bus12.err, bus12.rd_valid} !== 2'b10 || bus12.rdata !== 8'h5A) begin tests_failed++; $display("FAIL oor_read: err/valid=%b data=%h want 10/5a", {bus12.err, bus12.rd_valid}, bus12.rdata); end
    bus12.addr = 4'd12;
    tick();
    tests_run++; if (bus12.err !== 1'b1) begin tests_failed++; $display("FAIL oor_depth_boundary: err=%b want 1", bus12.err); end
    bus12.addr = 4'd5;
    tick();
    tests_run++; if (bus12.err !== 1'b0 || bus12.rdata !== 8'h5A) begin tests_failed++; $display("FAIL oor_no_change: err=%b data=%h want 0/5a", bus12.err, bus12.rdata); end
    idle12();
    tick();
  endtask

  task automatic test_busy_reset();
    int d16, d12;
    rst_n = 1'b0; idle16(); idle12();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    bus16.rd_en = 1'b1; bus16.addr = 4'd0;
    tick();
    tests_run++; if ({bus16.err, bus16.rd_valid, bus16.busy} !== 3'b101) begin tests_failed++; $display("FAIL busy_read_err: err/valid/busy=%b want 101", {bus16.err, bus16.rd_valid, bus16.busy}); end
    idle16();
    repeat (2) tick();
    rst_n = 1'b0; bus16.rd_en = 1'b1; bus16.addr = 4'd1;
    tick();
    tests_run++; if ({bus16.busy, bus16.err, bus16.rd_valid} !== 3'b100) begin tests_failed++; $display("FAIL midsweep_reset: busy/err/valid=%b want 100", {bus16.busy, bus16.err, bus16.rd_valid}); end
    idle16(); rst_n = 1'b1;
    count_busy(d16, d12);
    tests_run++; if (d16 != 16) begin tests_failed++; $display("FAIL restart_sweep_len: got %0d want 16", d16); end
  endtask

  task automatic test_ena_low();
    bus16.ena = 1'b0; bus16.wr_en = 1'b1; bus16.addr = 4'd2; bus16.wdata = 8'h3C; bus16.wmask = 8'hFF;
    tick();
    tests_run++; if ({bus16.rd_valid, bus16.conflict, bus16.err} !== 3'b000) begin tests_failed++; $display("FAIL ena_low_write_strobes: got %b want 000", {bus16.rd_valid, bus16.conflict, bus16.err}); end
    bus16.wr_en = 1'b0; bus16.rd_en = 1'b1;
    tick();
    tests_run++; if (bus16.rd_valid !== 1'b0) begin tests_failed++; $display("FAIL ena_low_read: rd_valid=%b want 0", bus16.rd_valid); end
    idle16(); bus16.rd_en = 1'b1; bus16.addr = 4'd2;
    tick();
    tests_run++; if (bus16.rdata !== 8'h00 || bus16.rd_valid !== 1'b1) begin tests_failed++; $display("FAIL ena_low_no_write: data=%h valid=%b want 00/1", bus16.rdata, bus16.rd_valid); end
    idle16(); bus16.wr_en = 1'b1; bus16.wmask = 8'hFF;
    for (int a = 1; a <= 3; a++) begin
      bus16.addr = 4'(a); bus16.wdata = 8'(a * 8'h11);
      tick();
    end
    idle16(); bus16.rd_en = 1'b1;
    for (int a = 1; a <= 3; a++) begin
      bus16.addr = 4'(a);
      tick();
      tests_run++; if (bus16.rd_valid !== 1'b1 || bus16.rdata !== 8'(a * 8'h11)) begin tests_failed++; $display("FAIL b2b_read[%0d]: valid=%b data=%h want 1/%h", a, bus16.rd_valid, bus16.rdata, 8'(a * 8'h11)); end
    end
    idle16();
    tick();
    tests_run++; if (bus16.rd_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_end: rd_valid=%b want 0", bus16.rd_valid); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    tests_run = 0; tests_failed = 0;
    idle16(); idle12();
    test_reset();
    test_write_read();
    test_conflict();
    test_out_of_range();
    test_busy_reset();
    test_ena_low();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
